// File: rtl/sram_bank_scheduler.sv
// Issues single-byte host requests to one of sixteen SPI SRAM controllers and
// returns read data to the host in request order, whatever order devices finish.
module sram_bank_scheduler #(
  parameter int P_TAG_DEPTH = 8,
  parameter int P_DEVS      = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_rd_n_wr,
  input  logic [3:0]   i_req_dev,
  input  logic [15:0]  i_req_addr,
  input  logic [7:0]   i_req_wdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [3:0]   o_rsp_dev,
  output logic [7:0]   o_rsp_data,
  output logic [15:0]  o_valid,
  output logic         o_rd_n_wr,
  output logic [15:0]  o_addr,
  output logic [7:0]   o_wdata,
  input  logic [15:0]  i_accept,
  input  logic [15:0]  i_ready,
  input  logic [127:0] i_rdata,
  output logic [15:0]  o_busy,
  output logic         o_idle
);

  localparam int PW = $clog2(P_TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(P_TAG_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t              state_q;
  logic [P_DEVS-1:0]   valid_q;
  logic                rd_n_wr_q;
  logic [15:0]         addr_q;
  logic [7:0]          wdata_q;

  logic [P_DEVS-1:0]   busy_q,   busy_d;
  logic [P_DEVS-1:0]   rdflag_q, rdflag_d;
  logic [P_DEVS-1:0]   have_q,   have_d;
  logic [7:0]          data_q [P_DEVS];
  logic [7:0]          data_d [P_DEVS];

  logic [3:0]          tag_mem [P_TAG_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q,  count_d;

  logic                req_fire, rsp_fire, push, pop, fifo_empty;
  logic [3:0]          head;
  logic [P_DEVS-1:0]   dev_onehot;

  // Both handshakes: a transfer happens on a clock edge where valid and ready
  // are both high; ready may depend combinationally on the request fields.
  assign o_req_ready = (state_q == S_IDLE) && !busy_q[i_req_dev] &&
                       (!i_req_rd_n_wr || (count_q < FULL_CNT));
  assign req_fire    = i_req_valid && o_req_ready;
  assign dev_onehot  = {{(P_DEVS-1){1'b0}}, 1'b1} << i_req_dev;

  assign fifo_empty  = (count_q == '0);
  assign head        = tag_mem[rd_ptr_q];
  assign o_rsp_valid = !fifo_empty && have_q[head];
  assign o_rsp_dev   = fifo_empty ? 4'd0 : head;
  assign o_rsp_data  = fifo_empty ? 8'd0 : data_q[head];
  assign rsp_fire    = o_rsp_valid && i_rsp_ready;

  assign push = req_fire && i_req_rd_n_wr;
  assign pop  = rsp_fire;

  assign o_valid   = valid_q;
  assign o_rd_n_wr = rd_n_wr_q;
  assign o_addr    = addr_q;
  assign o_wdata   = wdata_q;
  assign o_busy    = busy_q;
  assign o_idle    = (state_q == S_IDLE) && (busy_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      rd_n_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            state_q   <= S_ISSUE;
            valid_q   <= dev_onehot;
            rd_n_wr_q <= i_req_rd_n_wr;
            addr_q    <= i_req_addr;
            wdata_q   <= i_req_wdata;
          end
        end
        S_ISSUE: begin
          // Only the accept of the device being driven ends the issue.
          if ((i_accept & valid_q) != '0) begin
            state_q <= S_IDLE;
            valid_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Completion first, then response pop, so a consumed response always clears.
  always_comb begin
    busy_d   = busy_q;
    rdflag_d = rdflag_q;
    have_d   = have_q;
    data_d   = data_q;
    if (req_fire) begin
      busy_d[i_req_dev]   = 1'b1;
      rdflag_d[i_req_dev] = i_req_rd_n_wr;
    end
    for (int d = 0; d < P_DEVS; d++) begin
      if (i_ready[d] && busy_q[d]) begin
        if (rdflag_q[d]) begin
          have_d[d] = 1'b1;
          data_d[d] = i_rdata[8*d +: 8];
        end else begin
          busy_d[d] = 1'b0;
        end
      end
    end
    if (rsp_fire) begin
      have_d[head] = 1'b0;
      busy_d[head] = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q   <= '0;
      rdflag_q <= '0;
      have_q   <= '0;
      for (int d = 0; d < P_DEVS; d++) data_q[d] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      rdflag_q <= rdflag_d;
      have_q   <= have_d;
      data_q   <= data_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) tag_mem[wr_ptr_q] <= i_req_dev;
  end

endmodule
